// File: rtl/microbot_motor_pwm.sv
// microbot_motor_pwm: two-channel H-bridge drive stage.
// Takes signed per-motor speed commands over valid/ready, slews each
// channel's actual speed toward its target (1 LSB per ramp tick), inserts
// dead time on every direction reversal and emits registered PWM/dir pins.
// Optional feature macro: MICROBOT_BRAKE_EN (0x80 becomes a brake command).
module microbot_motor_pwm #(
  parameter int RAMP_DIV = 16,
  parameter int DEADTIME = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_motor,
  input  logic [7:0] cmd_speed,
  output logic       pwm_l,
  output logic       dir_l,
  output logic       pwm_r,
  output logic       dir_r,
  output logic       brake_l,
  output logic       brake_r,
  output logic       busy
);

  localparam int DATA_W = 8;
  localparam int PW = $clog2(RAMP_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);
  localparam logic [7:0] DEAD_INIT = 8'(DEADTIME);

  logic                     rst_q;
  logic [PW-1:0]            presc_q;
  logic                     tick;
  logic [6:0]               cnt_q;
  logic signed [DATA_W-1:0] cur_q [2];
  logic signed [DATA_W-1:0] tgt_q [2];
  logic [7:0]               dead_q [2];
  logic [1:0]               dir_q;
  logic [1:0]               pwm_p1;
  logic [1:0]               brake_q;
  logic                     accept;
  logic [1:0]               acc_ch;
  logic signed [DATA_W-1:0] cmd_tgt;
  logic                     cmd_brake;

  // -128 has no positive counterpart; clamp so |speed| always fits 7 bits
  function automatic logic signed [DATA_W-1:0] sat_speed(input logic signed [DATA_W-1:0] s);
    if (s == 8'sh80) return 8'sh81;
    return s;
  endfunction

  // Magnitude of a saturated speed (never -128)
  function automatic logic [6:0] mag7(input logic signed [DATA_W-1:0] s);
    logic signed [DATA_W-1:0] n;
    n = -s;
    return s[7] ? n[6:0] : s[6:0];
  endfunction

  assign cmd_ready = !rst_q && ena;
  assign accept    = cmd_valid && cmd_ready;
  assign acc_ch    = {accept && cmd_motor, accept && !cmd_motor};
  assign tick      = (presc_q == PRESC_MAX);

`ifdef MICROBOT_BRAKE_EN
  assign cmd_brake = (cmd_speed == 8'h80);
  assign cmd_tgt   = cmd_brake ? '0 : $signed(cmd_speed);

  // Brake flag: set by a brake command, cleared by the next accepted command
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      brake_q <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (acc_ch[ch]) brake_q[ch] <= cmd_brake;
      end
    end
  end
`else
  assign cmd_brake = 1'b0;
  assign cmd_tgt   = sat_speed($signed(cmd_speed));
  assign brake_q   = 2'b00;
`endif

  // Registered reset so ready rises one cycle after rst falls
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Shared ramp prescaler and PWM period counter; both hold while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else if (ena) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      cnt_q   <= (cnt_q == 7'd126) ? 7'd0 : cnt_q + 7'd1;
    end
  end

  // Per-channel ramp / dead-time state and registered PWM compare
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        cur_q[ch]  <= '0;
        tgt_q[ch]  <= '0;
        dead_q[ch] <= '0;
      end
      dir_q  <= 2'b00;
      pwm_p1 <= 2'b00;
    end else if (!ena) begin
      for (int ch = 0; ch < 2; ch++) begin
        cur_q[ch]  <= '0;
        tgt_q[ch]  <= '0;
        dead_q[ch] <= '0;
      end
      pwm_p1 <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (dead_q[ch] != 8'd0) begin
          dead_q[ch] <= dead_q[ch] - 8'd1;
        end else if (tick && (cur_q[ch] != tgt_q[ch])) begin
          if ((cur_q[ch] == 8'sd0) && (tgt_q[ch][7] != dir_q[ch])) begin
            dir_q[ch]  <= tgt_q[ch][7];
            dead_q[ch] <= DEAD_INIT;
          end else if (cur_q[ch] < tgt_q[ch]) begin
            cur_q[ch] <= cur_q[ch] + 8'sd1;
          end else begin
            cur_q[ch] <= cur_q[ch] - 8'sd1;
          end
        end
        // A newer command overrides the target even mid-ramp
        if (acc_ch[ch]) begin
          tgt_q[ch] <= cmd_tgt;
          if (cmd_brake) begin
            cur_q[ch]  <= '0;
            dead_q[ch] <= DEAD_INIT;
          end
        end
        // Pin stage: one cycle from cur/cnt to pin
        pwm_p1[ch] <= (dead_q[ch] == 8'd0) && !brake_q[ch] &&
                      !(acc_ch[ch] && cmd_brake) && (cnt_q < mag7(cur_q[ch]));
      end
    end
  end

  assign pwm_l   = pwm_p1[0];
  assign pwm_r   = pwm_p1[1];
  assign dir_l   = dir_q[0];
  assign dir_r   = dir_q[1];
  assign brake_l = brake_q[0];
  assign brake_r = brake_q[1];
  assign busy    = (cur_q[0] != tgt_q[0]) || (dead_q[0] != 8'd0) ||
                   (cur_q[1] != tgt_q[1]) || (dead_q[1] != 8'd0);

endmodule

// File: tb/tb_microbot_motor_pwm.sv
// Testbench for microbot_motor_pwm (default build, brake feature off).
module tb_microbot_motor_pwm;

  localparam int RAMP_DIV = 16;
  localparam int DEADTIME = 4;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_motor;
  logic [7:0] cmd_speed;
  logic       pwm_l, dir_l, pwm_r, dir_r, brake_l, brake_r, busy;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers)
  int m_cur [2];
  int m_tgt [2];
  int m_dead [2];
  bit m_dir [2];
  bit m_pwm [2];
  int m_presc;
  int m_cnt;
  bit m_rst_q;

  microbot_motor_pwm #(.RAMP_DIV(RAMP_DIV), .DEADTIME(DEADTIME)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_motor(cmd_motor), .cmd_speed(cmd_speed),
    .pwm_l(pwm_l), .dir_l(dir_l), .pwm_r(pwm_r), .dir_r(dir_r),
    .brake_l(brake_l), .brake_r(brake_r), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the behavioural model by one rising edge using the applied inputs
  function automatic void model_edge();
    bit rdy;
    bit tick;
    int mag;
    int s;
    rdy = !m_rst_q && ena;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_cur[c] = 0; m_tgt[c] = 0; m_dead[c] = 0; m_dir[c] = 0; m_pwm[c] = 0;
      end
      m_presc = 0;
      m_cnt   = 0;
    end else if (!ena) begin
      for (int c = 0; c < 2; c++) begin
        m_cur[c] = 0; m_tgt[c] = 0; m_dead[c] = 0; m_pwm[c] = 0;
      end
    end else begin
      tick = (m_presc == RAMP_DIV - 1);
      for (int c = 0; c < 2; c++) begin
        mag = (m_cur[c] < 0) ? -m_cur[c] : m_cur[c];
        m_pwm[c] = (m_dead[c] == 0) && (m_cnt < mag);
        if (m_dead[c] > 0) begin
          m_dead[c]--;
        end else if (tick && m_cur[c] != m_tgt[c]) begin
          if (m_cur[c] == 0 && ((m_tgt[c] < 0) != m_dir[c])) begin
            m_dir[c]  = (m_tgt[c] < 0);
            m_dead[c] = DEADTIME;
          end else begin
            m_cur[c] += (m_tgt[c] > m_cur[c]) ? 1 : -1;
          end
        end
      end
      if (cmd_valid && rdy) begin
        s = $signed(cmd_speed);
        if (s == -128) s = -127;
        m_tgt[cmd_motor] = s;
      end
      m_presc = (m_presc + 1) % RAMP_DIV;
      m_cnt   = (m_cnt + 1) % 127;
    end
    m_rst_q = rst;
  endfunction

  function automatic logic [7:0] exp_vec();
    bit b;
    b = 0;
    for (int c = 0; c < 2; c++) if (m_cur[c] != m_tgt[c] || m_dead[c] != 0) b = 1;
    return {m_pwm[0], m_dir[0], m_pwm[1], m_dir[1], 1'b0, 1'b0, b, !m_rst_q && ena};
  endfunction

  function automatic logic [7:0] act_vec();
    return {pwm_l, dir_l, pwm_r, dir_r, brake_l, brake_r, busy, cmd_ready};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_cmd(input logic m, input logic [7:0] s);
    cmd_valid = 1'b1;
    cmd_motor = m;
    cmd_speed = s;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; cmd_valid = 1'b0; cmd_motor = 1'b0; cmd_speed = 8'h00;
    repeat (3) step();
    checks++;
    if (act_vec() !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %b want %b", act_vec(), 8'h00);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b want 0", cmd_ready);
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_release got %b want 1", cmd_ready);
    end
    checks++;
    if (act_vec() !== exp_vec() || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got %b want %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_ramp_up();
    int n;
    int hi;
    send_cmd(1'b0, 8'd10);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL ramp_busy_start got %b want 1", busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step(); n++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL ramp_model cycle %0d got %b want %b", n, act_vec(), exp_vec());
      end
    end
    checks++;
    if (n > 160 || busy !== 1'b0) begin
      errors++; $display("FAIL ramp_time got %0d cycles busy=%b want <=160 busy=0", n, busy);
    end
    hi = 0;
    for (int i = 0; i < 127; i++) begin
      step(); hi += int'(pwm_l);
    end
    checks++;
    if (hi != 10 || dir_l !== 1'b0) begin
      errors++; $display("FAIL ramp_duty got %0d/127 dir=%b want 10/127 dir=0", hi, dir_l);
    end
  endtask

  task automatic test_reversal();
    int n;
    int hi;
    send_cmd(1'b0, 8'd2);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      step(); n++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL rev_settle_model got %b want %b", act_vec(), exp_vec());
      end
    end
    send_cmd(1'b0, 8'hFD);
    n = 0;
    while (dir_l !== 1'b1 && n < 300) begin
      step(); n++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL rev_down_model got %b want %b", act_vec(), exp_vec());
      end
    end
    checks++;
    if (dir_l !== 1'b1) begin
      errors++; $display("FAIL rev_dir_flip got %b want 1", dir_l);
    end
    for (int i = 0; i < DEADTIME; i++) begin
      step();
      checks++;
      if (pwm_l !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL rev_dead cycle %0d got pwm=%b busy=%b want pwm=0 busy=1", i, pwm_l, busy);
      end
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step(); n++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL rev_up_model got %b want %b", act_vec(), exp_vec());
      end
    end
    hi = 0;
    for (int i = 0; i < 127; i++) begin
      step(); hi += int'(pwm_l);
    end
    checks++;
    if (hi != 3 || dir_l !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rev_duty got %0d/127 dir=%b busy=%b want 3/127 dir=1 busy=0", hi, dir_l, busy);
    end
  endtask

  task automatic test_full_scale();
    int n;
    int hi;
    send_cmd(1'b1, 8'd127);
    n = 0;
    while (busy === 1'b1 && n < 2300) begin
      step(); n++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL fs_up_model got %b want %b", act_vec(), exp_vec());
      end
    end
    hi = 0;
    for (int i = 0; i < 127; i++) begin
      step(); hi += int'(pwm_r);
    end
    checks++;
    if (hi != 127 || dir_r !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fs_pos_duty got %0d/127 dir=%b busy=%b want 127/127 dir=0 busy=0", hi, dir_r, busy);
    end
    send_cmd(1'b1, 8'h80);
    n = 0;
    while (busy === 1'b1 && n < 4500) begin
      step(); n++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL fs_down_model got %b want %b", act_vec(), exp_vec());
      end
    end
    hi = 0;
    for (int i = 0; i < 127; i++) begin
      step(); hi += int'(pwm_r);
    end
    checks++;
    if (hi != 127 || dir_r !== 1'b1 || brake_r !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fs_neg_duty got %0d/127 dir=%b brake=%b busy=%b want 127/127 dir=1 brake=0 busy=0",
                         hi, dir_r, brake_r, busy);
    end
  endtask

  task automatic test_ena_drop();
    logic d;
    send_cmd(1'b0, 8'd20);
    for (int i = 0; i < 60; i++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL ena_pre_model got %b want %b", act_vec(), exp_vec());
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL ena_pre_busy got %b want 1", busy);
    end
    d = dir_l;
    ena = 1'b0;
    step();
    checks++;
    if (pwm_l !== 1'b0 || pwm_r !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0 || dir_l !== d) begin
      errors++; $display("FAIL ena_drop got pwm=%b%b ready=%b busy=%b dir=%b want 00 0 0 %b",
                         pwm_l, pwm_r, cmd_ready, busy, dir_l, d);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL ena_drop_model got %b want %b", act_vec(), exp_vec());
    end
    ena = 1'b1;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ena_restore_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid_dead();
    int n;
    send_cmd(1'b0, 8'd1);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      step(); n++;
    end
    checks++;
    if (act_vec() !== exp_vec() || busy !== 1'b0) begin
      errors++; $display("FAIL rstdead_settle got %b want %b", act_vec(), exp_vec());
    end
    send_cmd(1'b0, 8'hFB);
    n = 0;
    while (dir_l !== 1'b1 && n < 200) begin
      step(); n++;
    end
    step();
    checks++;
    if (dir_l !== 1'b1 || busy !== 1'b1 || pwm_l !== 1'b0) begin
      errors++; $display("FAIL rstdead_in_dead got dir=%b busy=%b pwm=%b want 1 1 0", dir_l, busy, pwm_l);
    end
    rst = 1'b1;
    step();
    checks++;
    if (act_vec() !== 8'h00) begin
      errors++; $display("FAIL rstdead_outputs got %b want %b", act_vec(), 8'h00);
    end
    rst = 1'b0;
    step();
    checks++;
    if (act_vec() !== exp_vec() || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstdead_release got %b want %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int r;
    int v;
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 299) == 0) ena = ~ena;
      cmd_valid = ($urandom_range(0, 59) == 0);
      cmd_motor = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 0) cmd_speed = 8'h80;
      else if (r == 1) cmd_speed = 8'h7F;
      else begin
        v = $urandom_range(0, 24);
        cmd_speed = ($urandom_range(0, 1) == 1) ? 8'(-v) : 8'(v);
      end
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_model cycle %0d got %b want %b", i, act_vec(), exp_vec());
      end
    end
    rst = 1'b0; ena = 1'b1; cmd_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_full_scale();
    test_ena_drop();
    test_reset_mid_dead();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
